// File: rtl/spi_rxq_if.sv
// Receive-side bus of spi_rxq: beat input, frame configuration, FIFO pop and status.
// master = block feeding beats and popping words, slave = spi_rxq itself.
interface spi_rxq_if #(
  parameter int LVL_W = 4
);
  logic             rx_en;
  logic [3:0]       shift_in;
  logic [1:0]       lane_mode;
  logic [4:0]       frm_len;
  logic             lsbf;
  logic [12:0]      spi_tnum;
  logic             crc_en;
  logic             crc_clr;
  logic [31:0]      crc_poly;
  logic             rd_en;
  logic             ovf_clr;
  logic [31:0]      rd_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic [LVL_W-1:0] fifo_lvl;
  logic             rx_ovf;
  logic             rx_busy;
  logic             rx_num_max_en;
  logic [31:0]      rx_crc_data_out;

  modport master (
    output rx_en, shift_in, lane_mode, frm_len, lsbf, spi_tnum,
           crc_en, crc_clr, crc_poly, rd_en, ovf_clr,
    input  rd_data, fifo_empty, fifo_full, fifo_lvl, rx_ovf, rx_busy,
           rx_num_max_en, rx_crc_data_out
  );

  modport slave (
    input  rx_en, shift_in, lane_mode, frm_len, lsbf, spi_tnum,
           crc_en, crc_clr, crc_poly, rd_en, ovf_clr,
    output rd_data, fifo_empty, fifo_full, fifo_lvl, rx_ovf, rx_busy,
           rx_num_max_en, rx_crc_data_out
  );
endinterface

// File: rtl/spi_rxq.sv
// SPI receive queue: 1/2/4-lane frame assembly into a first-word fall-through FIFO.
// Optional running CRC-32 over received bits when SPI_RXQ_CRC_EN is defined.
module spi_rxq #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic      clk_rx,
  input  logic      spi_rx_rstn,
  spi_rxq_if.slave  bus
);
  localparam int PTR_W = LVL_W - 1;

  logic             in_frame_q;
  logic [1:0]       mode_q;
  logic [4:0]       len_q;
  logic             lsbf_q;
  logic [5:0]       bit_cnt_q;
  logic [31:0]      asm_q;
  logic [12:0]      frm_cnt_q;
  logic             num_max_q;
  logic             busy_q;
  logic             ovf_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] cnt_q;
  logic [31:0]      mem [FIFO_DEPTH];

  logic [1:0]       cur_mode;
  logic [4:0]       cur_len;
  logic             cur_lsbf;
  logic [2:0]       lanes;
  logic [3:0]       beat_bits;
  logic [31:0]      asm_d;
  logic [5:0]       bits_after;
  logic [5:0]       n_bits;
  logic             frame_done;
  logic             last_frame;
  logic [31:0]      word_msb;
  logic [31:0]      word_rev;
  logic [31:0]      word;
  logic             fifo_empty_w;
  logic             fifo_full_w;
  logic             pop;
  logic             wr_ok;

  // Configuration is taken live on the first beat and from the latch afterwards.
  assign cur_mode = in_frame_q ? mode_q : bus.lane_mode;
  assign cur_len  = in_frame_q ? len_q  : bus.frm_len;
  assign cur_lsbf = in_frame_q ? lsbf_q : bus.lsbf;

  always_comb begin
    lanes     = 3'd1;
    beat_bits = {3'b000, bus.shift_in[0]};
    case (cur_mode)
      2'd1: begin lanes = 3'd2; beat_bits = {2'b00, bus.shift_in[1:0]}; end
      2'd2: begin lanes = 3'd4; beat_bits = bus.shift_in;               end
      default: ;
    endcase
  end

  assign asm_d      = (asm_q << lanes) | {28'd0, beat_bits};
  assign bits_after = bit_cnt_q + {3'd0, lanes};
  assign n_bits     = {1'b0, cur_len} + 6'd1;
  assign frame_done = bus.rx_en && (bits_after >= n_bits);
  assign last_frame = (frm_cnt_q == bus.spi_tnum);

  // Padding bits of the final beat sit below the word, so shift them out then mask.
  assign word_msb = (asm_d >> (bits_after - n_bits)) & (32'hFFFF_FFFF >> (6'd32 - n_bits));

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rev
      assign word_rev[gi] = word_msb[31-gi];
    end
  endgenerate

  assign word = cur_lsbf ? (word_rev >> (6'd32 - n_bits)) : word_msb;

  assign fifo_empty_w = (cnt_q == '0);
  assign fifo_full_w  = (cnt_q == LVL_W'(FIFO_DEPTH));
  assign pop          = bus.rd_en && !fifo_empty_w;
  assign wr_ok        = frame_done && (!fifo_full_w || pop);

  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) begin
      in_frame_q <= 1'b0;
      mode_q     <= 2'd0;
      len_q      <= 5'd0;
      lsbf_q     <= 1'b0;
      bit_cnt_q  <= 6'd0;
      asm_q      <= 32'd0;
      frm_cnt_q  <= 13'd0;
      num_max_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      num_max_q <= frame_done && last_frame;
      if (bus.rx_en) begin
        mode_q <= cur_mode;
        len_q  <= cur_len;
        lsbf_q <= cur_lsbf;
        busy_q <= !(frame_done && last_frame);
        if (frame_done) begin
          in_frame_q <= 1'b0;
          bit_cnt_q  <= 6'd0;
          asm_q      <= 32'd0;
          frm_cnt_q  <= last_frame ? 13'd0 : frm_cnt_q + 13'd1;
        end else begin
          in_frame_q <= 1'b1;
          bit_cnt_q  <= bits_after;
          asm_q      <= asm_d;
        end
      end
      if (frame_done && fifo_full_w && !pop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_ok, pop})
        2'b10:   cnt_q <= cnt_q + LVL_W'(1);
        2'b01:   cnt_q <= cnt_q - LVL_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_rx) begin
    if (wr_ok) mem[wr_ptr_q] <= word;
  end

  assign bus.rd_data       = fifo_empty_w ? 32'd0 : mem[rd_ptr_q];
  assign bus.fifo_empty    = fifo_empty_w;
  assign bus.fifo_full     = fifo_full_w;
  assign bus.fifo_lvl      = cnt_q;
  assign bus.rx_ovf        = ovf_q;
  assign bus.rx_busy       = busy_q;
  assign bus.rx_num_max_en = num_max_q;

`ifdef SPI_RXQ_CRC_EN
  logic [31:0] crc_q;
  logic [31:0] crc_step;
  logic        crc_fb;

  // Wire order within a beat is the top active lane first.
  always_comb begin
    crc_step = crc_q;
    crc_fb   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (i < int'(lanes)) begin
        crc_fb   = crc_step[31] ^ beat_bits[i];
        crc_step = {crc_step[30:0], 1'b0} ^ (crc_fb ? bus.crc_poly : 32'd0);
      end
    end
  end

  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) begin
      crc_q <= 32'd0;
    end else if (bus.crc_clr) begin
      crc_q <= 32'd0;
    end else if (bus.crc_en && bus.rx_en) begin
      crc_q <= crc_step;
    end
  end

  assign bus.rx_crc_data_out = crc_q;
`else
  logic unused_crc;
  assign unused_crc          = ^{bus.crc_en, bus.crc_clr, bus.crc_poly};
  assign bus.rx_crc_data_out = 32'd0;
`endif
endmodule

// File: doc/spi_rxq.md
SPI_RXQ -- requirements
Module: spi_rxq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO depth in words (power of 2, >=2).
REQ-002 SHALL have parameter LVL_W, default 4, FIFO level width (= log2(FIFO_DEPTH)+1).
REQ-003 clk_rx  in  1  single receive clock; all logic on rising edge.
REQ-004 spi_rx_rstn  in  1  asynchronous, active-low reset.
REQ-005 rx_en  in  1  beat valid; shift_in sampled on edges where high.
REQ-006 shift_in  in  4  serial data lanes; lane 0 only used in 1-lane mode.
REQ-007 lane_mode  in  2  0=1 lane, 1=2 lanes, 2=4 lanes, 3=reserved (treated as 1 lane).
REQ-008 frm_len  in  5  frame bits minus 1 (N = frm_len+1); legal N 4..32.
REQ-009 lsbf  in  1  1 = frame sent LSB first.
REQ-010 spi_tnum  in  13  frames per transfer minus 1.
REQ-011 crc_en  in  1  runtime CRC enable.
REQ-012 crc_clr  in  1  synchronous CRC clear.
REQ-013 crc_poly  in  32  CRC polynomial, implicit x^32.
REQ-014 rd_en  in  1  pop FIFO head.
REQ-015 ovf_clr  in  1  clear rx_ovf.
REQ-016 rd_data  out  32  FIFO head (first-word fall-through), zero-extended above N.
REQ-017 fifo_empty / fifo_full  out  1 each  FIFO status.
REQ-018 fifo_lvl  out  LVL_W  words held.
REQ-019 rx_ovf  out  1  sticky overflow flag.
REQ-020 rx_busy  out  1  transfer in progress.
REQ-021 rx_num_max_en  out  1  one-cycle pulse on last frame of transfer.
REQ-022 rx_crc_data_out  out  32  running CRC.

Function
REQ-023 lane_mode, frm_len, lsbf SHALL be latched on the first beat of each frame and held to its end.
REQ-024 Each beat SHALL shift L bits (L=1/2/4) into the assembly register MSB-first, shift_in[L-1] most significant within the beat.
REQ-025 A frame SHALL complete after ceil(N/L) beats; the word is the low N bits of the assembled value, excess low-order bits of the last beat discarded.
REQ-026 When lsbf=1, the N-bit word SHALL be bit-reversed over N bits before storage.
REQ-027 The completed word SHALL be written to the FIFO on the same edge that samples the last beat; fifo_empty falls immediately after that edge.
REQ-028 rx_en low mid-frame SHALL hold all assembly state (pause, no timeout).
REQ-029 rd_en with fifo_empty=1 SHALL be ignored; pop on the edge where rd_en=1, next head visible the following cycle.
REQ-030 Write while full without simultaneous pop SHALL drop the word and set rx_ovf; write and pop in the same cycle when full SHALL both succeed, level unchanged.
REQ-031 rx_ovf SHALL stay set until ovf_clr; simultaneous set and clear SHALL leave it set.
REQ-032 The frame counter SHALL count written-or-dropped frames 0..spi_tnum; on the frame equal to spi_tnum rx_num_max_en pulses for the cycle after the completing edge and the counter wraps to 0.
REQ-033 rx_busy SHALL be high from the edge after the first beat of a transfer until the edge completing its last frame.
REQ-034 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-035 Reset SHALL asynchronously clear assembly register, beat and frame counters, FIFO pointers, rx_ovf, CRC; outputs 0 except fifo_empty=1.
REQ-036 Reset mid-frame SHALL discard the partial frame; the next frame after release SHALL assemble cleanly.

Configuration
REQ-037 Macro SPI_RXQ_CRC_EN defined: CRC-32 register (init 0, MSB-first, no reflection, no xorout) SHALL process every received bit in wire order (shift_in[L-1] first per beat) while crc_en=1; crc_clr has priority and zeroes it.
REQ-038 SPI_RXQ_CRC_EN undefined: no CRC logic; rx_crc_data_out tied 0; crc_en, crc_clr, crc_poly ignored.

Verification
REQ-039 1 lane, N=8, lsbf=0, send 0xA5 MSB first -> rd_data=0x000000A5, fifo_lvl=1.
REQ-040 1 lane, N=16, lsbf=1, send 0xB971 bit0 first -> rd_data=0x0000B971.
REQ-041 4 lanes, N=32, spi_tnum=0, nibbles C,3,D,2,F,1,E,8 over 8 beats -> rd_data=0xC3D2F1E8, rx_num_max_en one pulse, rx_busy low after.
REQ-042 FIFO_DEPTH=4, five 8-bit frames, no reads -> fifo_full=1, rx_ovf=1, four reads return frames 1-4 in order.
REQ-043 With SPI_RXQ_CRC_EN, crc_en=1, poly 0x04C11DB7, 1 lane send 0x01 -> rx_crc_data_out=0x04C11DB7; crc_clr -> 0x00000000.
REQ-044 Assert reset after 3 bits of a frame, release, send 0x3C -> only 0x0000003C in FIFO, frame counter restarts at 0.
